exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order LoongArch32 pipeline; sits directly downstream of the decode stage and upstream of the memory stage.
- Latches the 148-bit decode bundle under valid/allowin handshake and computes the ALU result with an internal one-hot 12-op ALU.
- Issues the synchronous data-SRAM request for ld.w/st.w.
- Exports a forwarding/hazard collect back to decode and a bundle to the memory stage.

Parameters:
- DS2ES_W, 148, width of decode→execute bus
- ES2MS_W, 71, width of execute→memory bus

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ds_to_es_valid  in  1  decode bundle valid
- es_allowin  out  1  execute can accept a bundle this cycle
- ds_to_es_bus  in  148  {alu_op[11:0], res_from_mem, alu_src1[31:0], alu_src2[31:0], mem_we, rf_we, rf_waddr[4:0], rkd_value[31:0], pc[31:0]}, MSB first
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  execute bundle valid to memory stage
- es_to_ms_bus  out  71  {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}, MSB first
- es_rf_collect  out  39  {es_res_from_mem, es_rf_we, es_rf_waddr[4:0], alu_result[31:0]}
- data_sram_en  out  1  data SRAM access enable
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values:
  - es_valid=0 and every latched bus field=0.
  - Therefore es_to_ms_valid=0, data_sram_en=0, data_sram_we=0, es_rf_collect[37]=0.
  - Reset may assert mid-operation; any in-flight bundle is discarded immediately.
- Handshake:
  - es_ready_go=1: every op completes in one cycle.
  - es_allowin = ~es_valid | (es_ready_go & ms_allowin).
  - es_to_ms_valid = es_valid & es_ready_go.
- Register update at posedge:
  - If es_allowin, es_valid <= ds_to_es_valid.
  - If ds_to_es_valid & es_allowin, latch the whole bus; otherwise hold it.
  - Stall (es_valid & ~ms_allowin): hold all state, keep outputs stable, keep data_sram_en low.
- ALU (combinational on latched src1/src2; one-hot alu_op; result = OR of selected op outputs; alu_op==0 → result 0):
  - op0 add (32-bit wrap)
  - op1 sub
  - op2 signed less-than (result 1/0)
  - op3 unsigned less-than (result 1/0)
  - op4 and
  - op5 nor
  - op6 or
  - op7 xor
  - op8 sll by src2[4:0]
  - op9 srl by src2[4:0]
  - op10 sra (arithmetic) by src2[4:0]
  - op11 pass src2 (lu12i)
- Memory request:
  - data_sram_en = es_valid & (res_from_mem | mem_we) & ms_allowin, so the request fires exactly in the handoff cycle and read data returns in the memory stage's first cycle.
  - data_sram_we = {4{mem_we & es_valid & ms_allowin}}.
  - data_sram_addr = alu_result; data_sram_wdata = rkd_value.
  - No alignment check: the address is passed through unchanged.
- Forwarding collect:
  - es_rf_we = latched rf_we & es_valid; es_res_from_mem = latched res_from_mem & es_valid.
  - When es_valid=0, both flags are 0 so decode sees no hazard.
- Output bus: es_to_ms_bus carries latched res_from_mem, rf_we gated by es_valid, rf_waddr, alu_result and pc.
- Simultaneous drain+fill: with es_valid=1, ms_allowin=1 and ds_to_es_valid=1, the new bundle replaces the old one in the same edge, with no bubble.

Test Plan:
- Reset: resetn low async mid-cycle with a valid bundle held → es_valid, es_to_ms_valid, data_sram_en and es_rf_collect[37] drop immediately; es_allowin=1.
- add.w: src1=0x7FFFFFFF, src2=1, op0, rf_we=1, waddr=5 → alu_result 0x80000000 next cycle; es_rf_collect={0,1,5,0x80000000}.
- Compare and shift ops:
  - slt src1=0xFFFFFFFF, src2=1 → 1.
  - sltu same operands → 0.
  - sra 0x80000000 by src2=0x24 (amount 4) → 0xF8000000.
- st.w: src1=0x1000, src2=0xC, op0, mem_we=1, rkd_value=0xDEADBEEF, ms_allowin=1 → en=1, we=4'hF, addr=0x100C, wdata=0xDEADBEEF for one cycle.
- Back-pressure:
  - ld.w with ms_allowin=0 for 3 cycles → es_allowin=0, en=0, bus held.
  - ms_allowin rises → en=1 with we=0 that cycle and es_to_ms_valid handoff.
  - Upstream bundle is latched that same edge.
- Back-to-back bundles A, B, C with ms_allowin=1 → es_to_ms_bus shows A, B, C on consecutive cycles with no bubble; a branch bundle (alu_op=0) yields result 0 and rf_we=0.

Source files
------------

// File: rtl/exe_stage.sv
// ----------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage in-order LoongArch32 pipeline.
// Latches the decode bundle under a valid/allowin handshake, computes the ALU
// result with a one-hot 12-op ALU, issues the data-SRAM request for loads and
// stores, and exports a forwarding collect back to decode plus a bundle to the
// memory stage.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   ds_to_es_valid     decode bundle valid
//   es_allowin         execute can accept a bundle this cycle
//   ds_to_es_bus       {alu_op[11:0], res_from_mem, alu_src1, alu_src2,
//                       mem_we, rf_we, rf_waddr[4:0], rkd_value, pc}
//   ms_allowin         memory stage can accept
//   es_to_ms_valid     execute bundle valid to memory stage
//   es_to_ms_bus       {res_from_mem, rf_we, rf_waddr[4:0], alu_result, pc}
//   es_rf_collect      {es_res_from_mem, es_rf_we, es_rf_waddr[4:0], alu_result}
//   data_sram_*        synchronous data SRAM request (en, we[3:0], addr, wdata)
// ----------------------------------------------------------------------------
module exe_stage #(
    parameter int DS2ES_W = 148,
    parameter int ES2MS_W = 71
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ds_to_es_valid,
    output logic                 es_allowin,
    input  logic [DS2ES_W-1:0]   ds_to_es_bus,
    input  logic                 ms_allowin,
    output logic                 es_to_ms_valid,
    output logic [ES2MS_W-1:0]   es_to_ms_bus,
    output logic [38:0]          es_rf_collect,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_we,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata
);

    logic        r_es_valid;
    logic [11:0] r_alu_op;
    logic        r_res_from_mem;
    logic [31:0] r_alu_src1;
    logic [31:0] r_alu_src2;
    logic        r_mem_we;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rkd_value;
    logic [31:0] r_pc;

    logic        w_ready_go;
    logic        w_latch;
    logic [31:0] w_alu_result;

    logic [31:0] w_add;
    logic [31:0] w_sub;
    logic [31:0] w_slt;
    logic [31:0] w_sltu;
    logic [31:0] w_sll;
    logic [31:0] w_srl;
    logic [31:0] w_sra;
    logic [4:0]  w_sa;

    // Every operation finishes in a single cycle.
    assign w_ready_go     = 1'b1;
    assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
    assign es_to_ms_valid = r_es_valid & w_ready_go;
    assign w_latch        = ds_to_es_valid & es_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_es_valid     <= 1'b0;
            r_alu_op       <= '0;
            r_res_from_mem <= 1'b0;
            r_alu_src1     <= '0;
            r_alu_src2     <= '0;
            r_mem_we       <= 1'b0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rkd_value    <= '0;
            r_pc           <= '0;
        end else begin
            if (es_allowin) begin
                r_es_valid <= ds_to_es_valid;
            end
            if (w_latch) begin
                r_alu_op       <= ds_to_es_bus[147:136];
                r_res_from_mem <= ds_to_es_bus[135];
                r_alu_src1     <= ds_to_es_bus[134:103];
                r_alu_src2     <= ds_to_es_bus[102:71];
                r_mem_we       <= ds_to_es_bus[70];
                r_rf_we        <= ds_to_es_bus[69];
                r_rf_waddr     <= ds_to_es_bus[68:64];
                r_rkd_value    <= ds_to_es_bus[63:32];
                r_pc           <= ds_to_es_bus[31:0];
            end
        end
    end

    // One-hot ALU: each op result is masked by its select bit and OR-ed, so an
    // all-zero alu_op (e.g. a branch) yields zero.
    assign w_sa   = r_alu_src2[4:0];
    assign w_add  = r_alu_src1 + r_alu_src2;
    assign w_sub  = r_alu_src1 - r_alu_src2;
    assign w_slt  = {31'b0, ($signed(r_alu_src1) < $signed(r_alu_src2))};
    assign w_sltu = {31'b0, (r_alu_src1 < r_alu_src2)};
    assign w_sll  = r_alu_src1 << w_sa;
    assign w_srl  = r_alu_src1 >> w_sa;
    assign w_sra  = $unsigned($signed(r_alu_src1) >>> w_sa);

    always_comb begin
        w_alu_result = ({32{r_alu_op[0]}}  & w_add)
                     | ({32{r_alu_op[1]}}  & w_sub)
                     | ({32{r_alu_op[2]}}  & w_slt)
                     | ({32{r_alu_op[3]}}  & w_sltu)
                     | ({32{r_alu_op[4]}}  & (r_alu_src1 & r_alu_src2))
                     | ({32{r_alu_op[5]}}  & ~(r_alu_src1 | r_alu_src2))
                     | ({32{r_alu_op[6]}}  & (r_alu_src1 | r_alu_src2))
                     | ({32{r_alu_op[7]}}  & (r_alu_src1 ^ r_alu_src2))
                     | ({32{r_alu_op[8]}}  & w_sll)
                     | ({32{r_alu_op[9]}}  & w_srl)
                     | ({32{r_alu_op[10]}} & w_sra)
                     | ({32{r_alu_op[11]}} & r_alu_src2);
    end

    // The request fires only in the handoff cycle so read data lines up with
    // the memory stage's first cycle; a stall keeps it low.
    assign data_sram_en    = r_es_valid & (r_res_from_mem | r_mem_we) & ms_allowin;
    assign data_sram_we    = {4{r_mem_we & r_es_valid & ms_allowin}};
    assign data_sram_addr  = w_alu_result;
    assign data_sram_wdata = r_rkd_value;

    assign es_rf_collect = {r_res_from_mem & r_es_valid, r_rf_we & r_es_valid,
                            r_rf_waddr, w_alu_result};

    assign es_to_ms_bus  = {r_res_from_mem, r_rf_we & r_es_valid, r_rf_waddr,
                            w_alu_result, r_pc};

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    logic         clk;
    logic         resetn;
    logic         ds_to_es_valid;
    logic         es_allowin;
    logic [147:0] ds_to_es_bus;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [70:0]  es_to_ms_bus;
    logic [38:0]  es_rf_collect;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_cmp = 0;
    int n_err = 0;

    exe_stage #(.DS2ES_W(148), .ES2MS_W(71)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_to_es_valid  (ds_to_es_valid),
        .es_allowin      (es_allowin),
        .ds_to_es_bus    (ds_to_es_bus),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_rf_collect   (es_rf_collect),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [147:0] mk(input logic [11:0] op, input logic rfm,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic mw, input logic rw, input logic [4:0] wa,
                                        input logic [31:0] rkd, input logic [31:0] pc);
        return {op, rfm, s1, s2, mw, rw, wa, rkd, pc};
    endfunction

    // Reference ALU straight from the operation list.
    function automatic logic [31:0] ref_alu(input logic [11:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int sh;
        int signed sa;
        r  = 32'h0;
        sh = int'(b[4:0]);
        sa = $signed(a);
        for (int i = 0; i < 12; i++) begin
            if (op[i]) begin
                case (i)
                    0:  r |= a + b;
                    1:  r |= a - b;
                    2:  r |= ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3:  r |= (a < b) ? 32'd1 : 32'd0;
                    4:  r |= a & b;
                    5:  r |= ~(a | b);
                    6:  r |= a | b;
                    7:  r |= a ^ b;
                    8:  r |= a << sh;
                    9:  r |= a >> sh;
                    10: r |= 32'(sa >>> sh);
                    default: r |= b;
                endcase
            end
        end
        return r;
    endfunction

    // Model: a single slot holding whichever bundle the execute stage owns.
    logic         m_valid = 1'b0;
    logic [147:0] m_b     = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_b     <= '0;
        end else if (!m_valid || ms_allowin) begin
            m_valid <= ds_to_es_valid;
            if (ds_to_es_valid) m_b <= ds_to_es_bus;
        end
    end

    always @(negedge clk) begin
        logic [31:0] res;
        logic [11:0] op;
        logic        rfm, mw, rw;
        logic [4:0]  wa;
        op  = m_b[147:136];
        rfm = m_b[135];
        mw  = m_b[70];
        rw  = m_b[69];
        wa  = m_b[68:64];
        res = ref_alu(op, m_b[134:103], m_b[102:71]);
        chk("allowin", es_allowin, !m_valid || ms_allowin);
        chk("to_ms_valid", es_to_ms_valid, m_valid);
        chk("collect", es_rf_collect, {rfm & m_valid, rw & m_valid, wa, res});
        chk("sram_en", data_sram_en, m_valid & (rfm | mw) & ms_allowin);
        chk("sram_we", data_sram_we, {4{m_valid & mw & ms_allowin}});
        chk("sram_addr", data_sram_addr, res);
        chk("sram_wdata", data_sram_wdata, m_b[63:32]);
        if (m_valid) chk("to_ms_bus", es_to_ms_bus, {rfm, rw, wa, res, m_b[31:0]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [147:0] b);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = b;
    endtask

    logic [11:0] op_tab [12];

    initial begin
        resetn         = 1'b0;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        ms_allowin     = 1'b1;
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        step();
        chk("rst_valid", es_to_ms_valid, 1'b0);
        chk("rst_allowin", es_allowin, 1'b1);
        chk("rst_en", data_sram_en, 1'b0);

        // add.w overflow wrap
        drive(mk(12'h001, 1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b1, 5'd5, 32'h0, 32'h1c000000));
        step();
        chk("add_res", es_to_ms_bus[63:32], 32'h80000000);
        chk("add_collect", es_rf_collect, {1'b0, 1'b1, 5'd5, 32'h80000000});

        drive(mk(12'h004, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 5'd6, 32'h0, 32'h1c000004));
        step();
        chk("slt_res", es_to_ms_bus[63:32], 32'h1);
        drive(mk(12'h008, 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 5'd6, 32'h0, 32'h1c000008));
        step();
        chk("sltu_res", es_to_ms_bus[63:32], 32'h0);
        drive(mk(12'h400, 1'b0, 32'h80000000, 32'h24, 1'b0, 1'b1, 5'd6, 32'h0, 32'h1c00000c));
        step();
        chk("sra_res", es_to_ms_bus[63:32], 32'hF8000000);

        // every op once on mixed operands, checked by the model
        for (int i = 0; i < 12; i++) op_tab[i] = 12'(1 << i);
        for (int i = 0; i < 12; i++) begin
            drive(mk(op_tab[i], 1'b0, 32'h8F0F1234, 32'h80000013, 1'b0, 1'b1,
                     5'(i + 1), 32'h0, 32'h1c000010 + 32'(4 * i)));
            step();
        end
        drive(mk(12'h002, 1'b0, 32'h5, 32'h7, 1'b0, 1'b1, 5'd2, 32'h0, 32'h1c000040));
        step();
        chk("sub_res", es_to_ms_bus[63:32], 32'hFFFFFFFE);

        // st.w
        drive(mk(12'h001, 1'b0, 32'h1000, 32'hC, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h1c000080));
        step();
        chk("st_en", data_sram_en, 1'b1);
        chk("st_we", data_sram_we, 4'hF);
        chk("st_addr", data_sram_addr, 32'h100C);
        chk("st_wdata", data_sram_wdata, 32'hDEADBEEF);
        ds_to_es_valid = 1'b0;
        step();
        chk("st_done_en", data_sram_en, 1'b0);

        // ld.w under back-pressure
        drive(mk(12'h001, 1'b1, 32'h2000, 32'h4, 1'b0, 1'b1, 5'd7, 32'h0, 32'h1c000100));
        step();
        ms_allowin = 1'b0;
        drive(mk(12'h040, 1'b0, 32'h00F0, 32'h0F00, 1'b0, 1'b1, 5'd8, 32'h0, 32'h1c000104));
        repeat (3) begin
            step();
            chk("bp_allowin", es_allowin, 1'b0);
            chk("bp_en", data_sram_en, 1'b0);
            chk("bp_pc", es_to_ms_bus[31:0], 32'h1c000100);
        end
        ms_allowin = 1'b1;
        #1;
        chk("bp_rel_en", data_sram_en, 1'b1);
        chk("bp_rel_we", data_sram_we, 4'h0);
        chk("bp_rel_valid", es_to_ms_valid, 1'b1);
        chk("bp_rel_addr", data_sram_addr, 32'h2004);
        step();
        ds_to_es_valid = 1'b0;
        chk("bp_next_pc", es_to_ms_bus[31:0], 32'h1c000104);
        chk("bp_next_res", es_to_ms_bus[63:32], 32'h0FF0);
        step();

        // back-to-back A, B, C (C is a branch)
        drive(mk(12'h080, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 1'b0, 1'b1, 5'd9, 32'h0, 32'h1c000200));
        step();
        chk("a_pc", es_to_ms_bus[31:0], 32'h1c000200);
        drive(mk(12'h800, 1'b0, 32'h0, 32'h12345000, 1'b0, 1'b1, 5'd10, 32'h0, 32'h1c000204));
        step();
        chk("b_pc", es_to_ms_bus[31:0], 32'h1c000204);
        chk("b_res", es_to_ms_bus[63:32], 32'h12345000);
        drive(mk(12'h000, 1'b0, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1c000208));
        step();
        chk("c_pc", es_to_ms_bus[31:0], 32'h1c000208);
        chk("c_res", es_to_ms_bus[63:32], 32'h0);
        chk("c_rfwe", es_rf_collect[37], 1'b0);
        ds_to_es_valid = 1'b0;
        step();

        // asynchronous reset mid-cycle with a held bundle
        ms_allowin = 1'b0;
        drive(mk(12'h001, 1'b1, 32'h3000, 32'h0, 1'b0, 1'b1, 5'd11, 32'h0, 32'h1c000300));
        step();
        ds_to_es_valid = 1'b0;
        chk("pre_rst_valid", es_to_ms_valid, 1'b1);
        chk("pre_rst_rfwe", es_rf_collect[37], 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_valid", es_to_ms_valid, 1'b0);
        chk("mid_rst_en", data_sram_en, 1'b0);
        chk("mid_rst_rfwe", es_rf_collect[37], 1'b0);
        chk("mid_rst_allowin", es_allowin, 1'b1);
        @(posedge clk);
        #3 resetn = 1'b1;
        ms_allowin = 1'b1;
        step();
        chk("post_rst_valid", es_to_ms_valid, 1'b0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
